// File: rtl/ws2812_apb_chain_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ws2812_apb_chain_if                                       |
// | Purpose  : APB3 bus bundle for the WS2812 chain driver               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface ws2812_apb_chain_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface
`default_nettype wire

// File: rtl/ws2812_apb_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ws2812_apb_chain                                          |
// | Purpose  : APB3 slave streaming a pixel buffer to a WS2812 LED chain |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ws2812_apb_chain #(
   parameter int NUM_LEDS = 8,
   parameter int T_BIT    = 125,
   parameter int T1H      = 80,
   parameter int T0H      = 40,
   parameter int T_RESET  = 6000
) (
   input  wire                  PCLK,
   input  wire                  PRESET,
   ws2812_apb_chain_if.slave    apb,
   output logic                 LED,
   output logic                 IRQ
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PIX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [6:0]       C_LEN_MAX  = 7'(NUM_LEDS);
   localparam logic [9:0]       C_WA_CTRL  = 10'h200;
   localparam logic [9:0]       C_WA_LEN   = 10'h201;
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_HI1_LAST = CNT_W'(T1H - 1);
   localparam logic [CNT_W-1:0] C_HI0_LAST = CNT_W'(T0H - 1);
   localparam logic [CNT_W-1:0] C_LO1_LAST = CNT_W'(T_BIT - T1H - 1);
   localparam logic [CNT_W-1:0] C_LO0_LAST = CNT_W'(T_BIT - T0H - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(T_RESET - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_HIGH = 3'd2,
      ST_LOW  = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [23:0]      shift_q, shift_d;
   logic [4:0]       bit_idx_q, bit_idx_d;
   logic [6:0]       led_idx_q, led_idx_d;
   logic             led_q;

   logic [23:0]      pixel_q [NUM_LEDS];
   logic [6:0]       len_q;
   logic             ie_q;
   logic             done_q;
   logic             ovr_q;
   logic             start_q;
   logic [31:0]      prdata_q;

   // ------------------------------------------------------------------
   // Address decode and access qualification
   // ------------------------------------------------------------------
   logic [9:0]       w_waddr;
   logic [PIX_W-1:0] w_pix_idx;
   logic             w_is_pix_ok;
   logic             w_is_ctrl;
   logic             w_is_len;
   logic             w_map_ok;
   logic             w_busy;
   logic             w_err;
   logic             w_access;
   logic             w_wr;
   logic             w_start_req;
   logic             w_frame_end;
   logic [6:0]       w_len_wr;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_waddr     = apb.PADDR[11:2];
   assign w_pix_idx   = w_waddr[PIX_W-1:0];
   // Pixel window is everything below 0x800; only the first NUM_LEDS words exist.
   assign w_is_pix_ok = ~w_waddr[9] && (w_waddr < 10'(NUM_LEDS));
   assign w_is_ctrl   = (w_waddr == C_WA_CTRL);
   assign w_is_len    = (w_waddr == C_WA_LEN);
   assign w_map_ok    = w_is_pix_ok | w_is_ctrl | w_is_len;

   // A START accepted but not yet picked up by the FSM already counts as busy.
   assign w_busy      = start_q | (state_q != ST_IDLE);

   assign w_err       = ~w_map_ok | (apb.PWRITE & w_busy & (w_is_pix_ok | w_is_len));
   assign w_access    = apb.PSEL & apb.PENABLE;
   assign w_wr        = w_access & apb.PWRITE & ~w_err;
   assign w_start_req = w_wr & w_is_ctrl & apb.PWDATA[0];
   assign w_frame_end = (state_q == ST_GAP) && (state_d == ST_IDLE);
   assign w_len_wr    = (apb.PWDATA[6:0] > C_LEN_MAX) ? C_LEN_MAX : apb.PWDATA[6:0];

   assign apb.PSLVERR = w_access & w_err;
   assign apb.PREADY  = 1'b1;
   assign apb.PRDATA  = prdata_q;
   assign LED         = led_q;
   assign IRQ         = done_q & ie_q;

   assign w_unused    = ^{apb.PADDR[31:12], apb.PADDR[1:0], apb.PWDATA[31:24]};

   // Read mux; unmapped offsets read as zero.
   always_comb begin
      w_rdata = 32'd0;
      if (w_is_pix_ok) begin
         w_rdata = {8'd0, pixel_q[w_pix_idx]};
      end else if (w_is_ctrl) begin
         w_rdata = {21'd0, ovr_q, done_q, w_busy, 6'd0, ie_q, 1'b0};
      end else if (w_is_len) begin
         w_rdata = {25'd0, len_q};
      end
   end

   // Read data is captured in the setup phase and held through the access phase.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         prdata_q <= 32'd0;
      end else if (apb.PSEL & ~apb.PENABLE & ~apb.PWRITE) begin
         prdata_q <= w_rdata;
      end
   end

   // Pixel buffer: written only by successful APB writes.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            pixel_q[i] <= 24'd0;
         end
      end else if (w_wr & w_is_pix_ok) begin
         pixel_q[w_pix_idx] <= apb.PWDATA[23:0];
      end
   end

   // Control/status: IE, DONE/OVERRUN sticky flags, LEN and the start request.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         ie_q    <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         start_q <= 1'b0;
         len_q   <= C_LEN_MAX;
      end else begin
         start_q <= w_start_req & ~w_busy;
         if (w_wr & w_is_ctrl) begin
            ie_q <= apb.PWDATA[1];
            if (apb.PWDATA[9]) begin
               done_q <= 1'b0;
            end
            if (apb.PWDATA[10]) begin
               ovr_q <= 1'b0;
            end
         end
         if (w_start_req & w_busy) begin
            ovr_q <= 1'b1;
         end
         if (w_start_req & ~w_busy) begin
            done_q <= 1'b0;
         end
         // Hardware set is last so it wins over a simultaneous W1C.
         if (w_frame_end) begin
            done_q <= 1'b1;
         end
         if (w_wr & w_is_len) begin
            len_q <= w_len_wr;
         end
      end
   end

   // Frame sequencer state register; LED follows the next state so it is glitch-free.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shift_q   <= 24'd0;
         bit_idx_q <= 5'd0;
         led_idx_q <= 7'd0;
         led_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         led_idx_q <= led_idx_d;
         led_q     <= (state_d == ST_HIGH);
      end
   end

   // Frame sequencer next-state: LOAD/HIGH/LOW per bit, GAP latch after the last pixel.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + C_CNT_ONE;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      led_idx_d = led_idx_q;

      case (state_q)
         ST_IDLE: begin
            if (start_q) begin
               state_d   = ST_LOAD;
               led_idx_d = 7'd0;
            end
         end
         ST_LOAD: begin
            shift_d   = pixel_q[led_idx_q[PIX_W-1:0]];
            bit_idx_d = 5'd23;
            state_d   = (len_q == 7'd0) ? ST_GAP : ST_HIGH;
         end
         ST_HIGH: begin
            if (cnt_q == (shift_q[23] ? C_HI1_LAST : C_HI0_LAST)) begin
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (cnt_q == (shift_q[23] ? C_LO1_LAST : C_LO0_LAST)) begin
               if (bit_idx_q != 5'd0) begin
                  state_d   = ST_HIGH;
                  shift_d   = {shift_q[22:0], 1'b0};
                  bit_idx_d = bit_idx_q - 5'd1;
               end else if (led_idx_q == (len_q - 7'd1)) begin
                  state_d = ST_GAP;
               end else begin
                  state_d   = ST_LOAD;
                  led_idx_d = led_idx_q + 7'd1;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == C_GAP_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Every state times itself from zero.
      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_apb_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ws2812_apb_chain                                       |
// | Purpose  : scoreboard bench for ws2812_apb_chain                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ws2812_apb_chain;
   localparam int NUM_LEDS = 8;
   localparam int T_BIT    = 125;
   localparam int T1H      = 80;
   localparam int T0H      = 40;
   localparam int T_RESET  = 6000;
   localparam int PIX_CYC  = 24 * T_BIT + 1;

   localparam logic [31:0] A_CTRL = 32'h800;
   localparam logic [31:0] A_LEN  = 32'h804;

   logic PCLK   = 1'b0;
   logic PRESET = 1'b1;
   logic LED;
   logic IRQ;

   ws2812_apb_chain_if apb ();

   ws2812_apb_chain #(
      .NUM_LEDS (NUM_LEDS),
      .T_BIT    (T_BIT),
      .T1H      (T1H),
      .T0H      (T0H),
      .T_RESET  (T_RESET)
   ) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .apb    (apb.slave),
      .LED    (LED),
      .IRQ    (IRQ)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- LED pulse scoreboard ----------------
   typedef struct { int rise; int width; } pulse_t;
   pulse_t led_exp[$];
   pulse_t cur;
   bit     mon_en   = 1'b1;
   bit     have_cur = 1'b0;
   logic   led_prev = 1'b0;
   int     rise_at  = 0;

   always @(negedge PCLK) begin
      if (mon_en) begin
         if (LED === 1'b1 && led_prev !== 1'b1) begin
            check_eq("led_rise_expected", 32'(led_exp.size() != 0), 32'd1);
            if (led_exp.size() != 0) begin
               cur      = led_exp.pop_front();
               check_eq("led_rise_cyc", cyc, cur.rise);
               rise_at  = cyc;
               have_cur = 1'b1;
            end
         end else if (LED !== 1'b1 && led_prev === 1'b1 && have_cur) begin
            check_eq("led_width", cyc - rise_at, cur.width);
            have_cur = 1'b0;
         end
      end else begin
         have_cur = 1'b0;
      end
      led_prev = LED;
   end

   logic [23:0] pix_m [NUM_LEDS];

   task automatic push_frame(input int e, input int len);
      logic [23:0] px;
      for (int p = 0; p < len; p++) begin
         px = pix_m[p];
         for (int b = 23; b >= 0; b--) begin
            led_exp.push_back('{e + 2 + p * PIX_CYC + (23 - b) * T_BIT,
                                px[b] ? T1H : T0H});
         end
      end
   endtask

   // ---------------- APB read scoreboard ----------------
   typedef struct { logic [31:0] data; logic err; } rd_t;
   rd_t rd_exp[$];
   int  wr_edge = 0;

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_err, input string tag);
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
      apb.PADDR = addr; apb.PWDATA = data;
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1;
      #1;
      check_eq({tag, "_slverr"}, 32'(apb.PSLVERR), 32'(exp_err));
      @(posedge PCLK); #1;
      wr_edge = cyc;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp,
                           input logic exp_err, input string tag);
      rd_t r;
      rd_exp.push_back('{exp, exp_err});
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1;
      #1;
      r = rd_exp.pop_front();
      check_eq({tag, "_slverr"}, 32'(apb.PSLVERR), 32'(r.err));
      check_eq({tag, "_data"}, apb.PRDATA, r.data);
      @(posedge PCLK); #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge PCLK); #1;
      end
   endtask

   // Returns the edge number on which IRQ was first seen high, or -1 on timeout.
   task automatic wait_irq(input int deadline, output int at);
      at = -1;
      while (cyc <= deadline && at < 0) begin
         if (IRQ === 1'b1) at = cyc;
         else begin
            @(posedge PCLK); #1;
         end
      end
   endtask

   int e;
   int irq_at;
   int t_end;
   int r_bit;

   initial begin
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      apb.PADDR = 32'd0; apb.PWDATA = 32'd0;
      for (int i = 0; i < NUM_LEDS; i++) pix_m[i] = 24'd0;

      // Reset state
      repeat (3) @(posedge PCLK);
      #1;
      check_eq("rst_led", 32'(LED), 32'd0);
      check_eq("rst_irq", 32'(IRQ), 32'd0);
      check_eq("rst_prdata", apb.PRDATA, 32'd0);
      PRESET = 1'b0;
      apb_read(A_CTRL, 32'h0, 1'b0, "rst_ctrl");
      apb_read(A_LEN, 32'(NUM_LEDS), 1'b0, "rst_len");
      apb_read(32'h0, 32'h0, 1'b0, "rst_pix0");
      check_eq("idle_led", 32'(LED), 32'd0);

      // Single pixel 0x800001
      apb_write(32'h0, 32'h0080_0001, 1'b0, "wr_pix0");
      pix_m[0] = 24'h800001;
      apb_write(A_LEN, 32'd1, 1'b0, "wr_len1");
      apb_read(A_LEN, 32'd1, 1'b0, "rd_len1");
      apb_write(A_CTRL, 32'h1, 1'b0, "start1");
      e = wr_edge;
      push_frame(e, 1);
      apb_read(A_CTRL, 32'h100, 1'b0, "busy1");
      wait_cyc(e + 1 + PIX_CYC + T_RESET);
      apb_read(A_CTRL, 32'h200, 1'b0, "done1");
      check_eq("led_drain1", 32'(led_exp.size()), 32'd0);

      // Three pixels, IRQ timing, errors and overrun while busy
      apb_write(32'h4, 32'hFF5A_0F0F, 1'b0, "wr_pix1");
      pix_m[1] = 24'h5A0F0F;
      apb_write(32'h8, 32'h0000_FFFF, 1'b0, "wr_pix2");
      pix_m[2] = 24'h00FFFF;
      apb_read(32'h4, 32'h005A_0F0F, 1'b0, "rd_pix1_hi0");
      apb_write(A_LEN, 32'd3, 1'b0, "wr_len3");
      apb_write(A_CTRL, 32'h3, 1'b0, "start3");
      e = wr_edge;
      push_frame(e, 3);
      apb_write(32'h4, 32'h00FF_FFFF, 1'b1, "busy_pix_wr");
      apb_write(A_LEN, 32'd1, 1'b1, "busy_len_wr");
      apb_write(A_CTRL, 32'h3, 1'b0, "busy_start");
      apb_read(A_CTRL, 32'h502, 1'b0, "ovr_set");
      apb_read(32'h4, 32'h005A_0F0F, 1'b0, "pix1_kept");
      apb_read(A_LEN, 32'd3, 1'b0, "len_kept");
      t_end = e + 1 + 3 * PIX_CYC + T_RESET;
      wait_irq(t_end + 50, irq_at);
      check_eq("irq_time", irq_at, t_end);
      check_eq("led_drain3", 32'(led_exp.size()), 32'd0);
      apb_read(A_CTRL, 32'h602, 1'b0, "done3");
      apb_write(A_CTRL, 32'h602, 1'b0, "w1c");
      check_eq("irq_drop", 32'(IRQ), 32'd0);
      apb_read(A_CTRL, 32'h002, 1'b0, "ctrl_cleared");

      // LEN clamp, out-of-range and unmapped reads, empty frame
      apb_write(A_LEN, 32'd100, 1'b0, "wr_len100");
      apb_read(A_LEN, 32'(NUM_LEDS), 1'b0, "len_clamp");
      apb_read(32'h20, 32'h0, 1'b1, "oob_pix");
      apb_read(32'h808, 32'h0, 1'b1, "unmapped");
      apb_write(32'h20, 32'h1234, 1'b1, "oob_pix_wr");
      apb_write(A_LEN, 32'd0, 1'b0, "wr_len0");
      apb_write(A_CTRL, 32'h3, 1'b0, "start0");
      e = wr_edge;
      wait_irq(e + T_RESET + 50, irq_at);
      check_eq("len0_irq_window",
               32'((irq_at >= e + 1 + T_RESET) && (irq_at <= e + 2 + T_RESET)), 32'd1);
      apb_write(A_CTRL, 32'h200, 1'b0, "w1c0");
      apb_read(A_CTRL, 32'h0, 1'b0, "ctrl_after0");

      // Reset in the middle of bit 10 of pixel 1
      apb_write(A_LEN, 32'd2, 1'b0, "wr_len2");
      apb_write(A_CTRL, 32'h1, 1'b0, "start2");
      e = wr_edge;
      push_frame(e, 2);
      r_bit = e + 2 + PIX_CYC + 13 * T_BIT;
      wait_cyc(r_bit + 9);
      check_eq("pre_rst_led", 32'(LED), 32'd1);
      mon_en = 1'b0;
      led_exp.delete();
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      check_eq("rst_mid_led", 32'(LED), 32'd0);
      check_eq("rst_mid_prdata", apb.PRDATA, 32'd0);
      PRESET = 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) pix_m[i] = 24'd0;
      apb_read(A_CTRL, 32'h0, 1'b0, "rst_mid_ctrl");
      apb_read(32'h4, 32'h0, 1'b0, "rst_mid_pix1");
      check_eq("rst_mid_led_low", 32'(LED), 32'd0);
      mon_en = 1'b1;
      apb_write(32'h0, 32'h00A5_C33C, 1'b0, "wr_pix0b");
      pix_m[0] = 24'hA5C33C;
      apb_write(A_LEN, 32'd1, 1'b0, "wr_len1b");
      apb_write(A_CTRL, 32'h1, 1'b0, "start_after_rst");
      e = wr_edge;
      push_frame(e, 1);
      wait_cyc(e + 1 + PIX_CYC + T_RESET);
      apb_read(A_CTRL, 32'h200, 1'b0, "done_after_rst");
      check_eq("led_drain_rst", 32'(led_exp.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ws2812_apb_chain.md
# ws2812_apb_chain

APB3 slave that streams a parametrised chain of WS2812-class addressable LEDs from an internal pixel buffer. It is the generalised successor to the fixed 8-LED driver. Adds:
- configurable chain length and bit timing;
- an explicit start/busy/done control model;
- error responses and a frame-done interrupt.

It sits on the APB3 fabric next to the other memory-mapped peripherals and drives one serial LED data pin.

## Interface
Parameters:
- NUM_LEDS, 8, pixel buffer depth (1..64)
- T_BIT, 125, PCLK cycles per data bit
- T1H, 80, high cycles for a '1' bit (T0H < T1H < T_BIT)
- T0H, 40, high cycles for a '0' bit (0 < T0H)
- T_RESET, 6000, low cycles of the latch/reset gap after a frame

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address; only PADDR[11:2] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  error response, valid in access phase
- LED  out  1  serial data to first LED, registered
- IRQ  out  1  level interrupt = DONE & IE

## Operation
Address map (offsets, word aligned):
- 0x000 + 4*i, i < NUM_LEDS: PIXEL[i], bits [23:0] GRB, bits [31:24] read 0.
- 0x800 CTRL:
  - W1 bit0 START;
  - bit1 IE (RW);
  - bit8 BUSY (RO);
  - bit9 DONE (RW1C);
  - bit10 OVERRUN (RW1C).
- 0x804 LEN: bits [6:0] = LEDs per frame; reset value NUM_LEDS; writes above NUM_LEDS clamp to NUM_LEDS.

Transfers and error responses:
- Write occurs when PSEL & PENABLE & PWRITE and PSLVERR = 0.
- PSLVERR = 1 in the access phase for any of:
  - pixel index ≥ NUM_LEDS;
  - unmapped offset;
  - PIXEL or LEN write while BUSY.
- Errored writes have no effect. Errored reads return 0.

Frame sequencing:
- START while idle: set BUSY, clear DONE, start frame.
- START while BUSY: ignored; OVERRUN set.
- START with LEN = 0: frame is the reset gap only.
- Bit order: PIXEL[0] first, bit 23 down to bit 0, then PIXEL[1], ... PIXEL[LEN-1].

FSM states:
- IDLE: LED=0. START → LOAD.
- LOAD (1 cycle): fetch PIXEL[led_idx] into 24-bit shift register, bit_idx=23. → HIGH, or → GAP if LEN=0.
- HIGH: LED=1 for T1H or T0H cycles per current bit. → LOW.
- LOW: LED=0 until T_BIT total cycles of the bit have elapsed.
  - More bits in pixel → HIGH with next bit.
  - Last bit, more pixels → LOAD.
  - Last bit of pixel LEN-1 → GAP.
- GAP: LED=0 for T_RESET cycles. → IDLE; clear BUSY, set DONE.

Counter and shifter widths:
- Cycle counter is ceil(log2(max(T_BIT, T_RESET)+1)) bits and restarts at 0 on each state entry.
- The shift register is loaded only in LOAD, so pixel writes cannot corrupt a frame in flight.

## Timing
Reset (PRESET=1 at an edge) forces, on that edge:
- LED=0, PRDATA=0, IRQ=0;
- state IDLE, BUSY=DONE=OVERRUN=IE=0;
- LEN=NUM_LEDS, all PIXEL=0.

Reset mid-frame aborts immediately; LED is low the same edge.

APB:
- PRDATA registered in the setup phase (PSEL & ~PENABLE), stable during the access phase.
- Register writes take effect on the access-phase edge; a read in the next transfer sees the new value.

Frame timing:
- START written on edge E:
  - BUSY reads 1 from E+1;
  - LOAD occupies cycle E+1;
  - LED rises at edge E+2.
- Each bit occupies exactly T_BIT cycles:
  - '1' bit: high T1H, low T_BIT−T1H;
  - '0' bit: high T0H, low T_BIT−T0H.
- Each pixel boundary inserts the 1-cycle LOAD (LED=0). The first pixel's LOAD precedes the first rising edge.
- Total frame = LEN*(24*T_BIT+1) + T_RESET cycles from E+1 to the IDLE entry edge.
- DONE and IRQ assert on the edge that enters IDLE.

Simultaneous events:
- DONE clear (W1C) in the same cycle as hardware DONE set: set wins.
- START write in the IDLE-entry cycle is treated as BUSY; OVERRUN set.

## Test plan
- Reset, read CTRL and LEN → CTRL=0x0, LEN=NUM_LEDS. Read PIXEL[0] → 0. LED=0 throughout.
- Write PIXEL[0]=0x800001, LEN=1, START → LED pattern: bit23 high 80/low 45, bits 22..1 high 40/low 85, bit0 high 80/low 45. Then 6000 low cycles, then DONE=1.
- IE=1, LEN=3, START:
  - IRQ rises exactly 3*(24*125+1)+6000 cycles after BUSY rises;
  - W1C DONE drops IRQ next cycle.
- During BUSY:
  - write PIXEL[1] → PSLVERR=1, value unchanged;
  - write START → OVERRUN=1, frame length unchanged.
- Write LEN=100 with NUM_LEDS=8 → reads 8. Read offset 0x020 → PSLVERR=1, PRDATA=0. LEN=0 START → LED low 6000 cycles, then DONE.
- Assert PRESET at bit 10 of pixel 1 → LED=0, BUSY=0 on that edge. A subsequent START produces a full frame from PIXEL[0].
